// File: rtl/lock_pkg.sv
// lock_pkg: shared state/selector encoding and width helpers for the combination lock
package lock_pkg;
  typedef enum logic [2:0] {
    S_LOCKED      = 3'd0,
    S_ENTRY       = 3'd1,
    S_OPEN        = 3'd2,
    S_CHG_NEW     = 3'd3,
    S_CHG_CONFIRM = 3'd4,
    S_LOCKOUT     = 3'd5
  } state_t;
  localparam int TRY_W = 4;
  function automatic int idx_w(input int code_len);
    return $clog2(code_len + 1);
  endfunction
endpackage

// File: rtl/lockout_timer.sv
// lockout_timer: loadable down-counter that flags its final cycle with a one-cycle done
module lockout_timer #(
  parameter int CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic done
);
  localparam int W = $clog2(CYCLES);
  logic [W-1:0] cnt;
  logic run;
  // load starts a run of CYCLES cycles; the run ends in the cycle after cnt reaches zero
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      run <= 1'b0;
    end else if (load) begin
      cnt <= W'(CYCLES - 1);
      run <= 1'b1;
    end else if (run) begin
      cnt <= cnt - W'(1);
      run <= cnt != '0;
    end
  assign done = run & (cnt == '0);
endmodule

// File: rtl/combo_lock_core.sv
// combo_lock_core: N-digit combination lock with retry limit, timed lockout and verified code change; defining LOCK_DURESS_EN adds a reversed-code silent alarm
module combo_lock_core
  import lock_pkg::*;
#(
  parameter int CODE_LEN = 4,
  parameter int DIGIT_W = 4,
  parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = 16'h1234,
  parameter int MAX_TRIES = 3,
  parameter int LOCKOUT_CYCLES = 1024
) (
  input  logic                          Clock,
  input  logic                          Reset_n,
  input  logic                          Open_Close,
  input  logic                          Validate,
  input  logic                          Change,
  input  logic [DIGIT_W-1:0]            Number,
  output logic                          Unlocked,
  output logic                          Alarm,
  output logic                          Duress,
  output logic [$clog2(CODE_LEN+1)-1:0] Digit_Idx,
  output logic [TRY_W-1:0]              Tries_Left,
  output logic [2:0]                    Selector
);
  localparam int IW = idx_w(CODE_LEN);
  localparam int CW = CODE_LEN * DIGIT_W;
`ifdef LOCK_DURESS_EN
  localparam bit DURESS_EN = 1'b1;
`else
  localparam bit DURESS_EN = 1'b0;
`endif
  localparam logic [IW-1:0] LAST = IW'(CODE_LEN - 1);
  state_t state_q, state_n;
  logic [CW-1:0] code_q, code_n, shadow_q, shadow_n;
  logic [IW-1:0] idx_n;
  logic [TRY_W-1:0] tries_n;
  logic mm_q, mm_n, mr_q, mr_n, duress_n;
  logic oc, ch, va, last, fwd_bad, rev_bad, shd_bad, rev_ok, load, done;
  // digit 0 lives in the most significant bits
  function automatic logic [DIGIT_W-1:0] dig(input logic [CW-1:0] v, input logic [IW-1:0] i);
    return v[(CODE_LEN - 1 - int'(i)) * DIGIT_W +: DIGIT_W];
  endfunction
  lockout_timer #(.CYCLES(LOCKOUT_CYCLES)) u_timer (
    .clk  (Clock),
    .rst_n(Reset_n),
    .load (load),
    .done (done)
  );
  // next-state logic: resolve pulse priority, then step the lock state machine
  always_comb begin
    oc = Open_Close;
    ch = Change & ~Open_Close;
    va = Validate & ~Open_Close & ~Change;
    last = Digit_Idx == LAST;
    fwd_bad = Number != dig(code_q, Digit_Idx);
    rev_bad = Number != dig(code_q, LAST - Digit_Idx);
    shd_bad = Number != dig(shadow_q, Digit_Idx);
    state_n = state_q;
    code_n = code_q;
    shadow_n = shadow_q;
    idx_n = Digit_Idx;
    tries_n = Tries_Left;
    mm_n = mm_q;
    mr_n = mr_q;
    duress_n = Duress;
    load = 1'b0;
    rev_ok = 1'b0;
    case (state_q)
      S_LOCKED: if (va) begin
        state_n = S_ENTRY;
        idx_n = IW'(1);
        mm_n = fwd_bad;
        mr_n = rev_bad;
      end
      S_ENTRY: if (oc) begin
        state_n = S_LOCKED;
        idx_n = '0;
      end else if (va) begin
        idx_n = last ? '0 : Digit_Idx + IW'(1);
        mm_n = mm_q | fwd_bad;
        mr_n = mr_q | rev_bad;
        rev_ok = DURESS_EN & ~mr_n;
        if (last) begin
          if (!mm_n) begin
            state_n = S_OPEN;
            tries_n = TRY_W'(MAX_TRIES);
          end else if (rev_ok) begin
            state_n = S_OPEN;
            duress_n = 1'b1;
          end else if (Tries_Left == TRY_W'(1)) begin
            state_n = S_LOCKOUT;
            tries_n = '0;
            load = 1'b1;
          end else begin
            state_n = S_LOCKED;
            tries_n = Tries_Left - TRY_W'(1);
          end
        end
      end
      S_OPEN: state_n = oc ? S_LOCKED : ch ? S_CHG_NEW : S_OPEN;
      S_CHG_NEW, S_CHG_CONFIRM: if (oc) begin
        state_n = S_OPEN;
        idx_n = '0;
        shadow_n = '0;
      end else if (va) begin
        idx_n = last ? '0 : Digit_Idx + IW'(1);
        if (state_q == S_CHG_NEW) begin
          shadow_n[(CODE_LEN - 1 - int'(Digit_Idx)) * DIGIT_W +: DIGIT_W] = Number;
          mm_n = 1'b0;
          if (last) state_n = S_CHG_CONFIRM;
        end else begin
          mm_n = mm_q | shd_bad;
          if (last) begin
            state_n = S_OPEN;
            shadow_n = '0;
            if (!mm_n) code_n = shadow_q;
          end
        end
      end
      S_LOCKOUT: if (done) begin
        state_n = S_LOCKED;
        tries_n = TRY_W'(MAX_TRIES);
      end
      default: state_n = S_LOCKED;
    endcase
  end
  // state, code storage and registered outputs
  always_ff @(posedge Clock or negedge Reset_n)
    if (!Reset_n) begin
      state_q <= S_LOCKED;
      code_q <= DEFAULT_CODE;
      shadow_q <= '0;
      Digit_Idx <= '0;
      mm_q <= 1'b0;
      mr_q <= 1'b0;
      Tries_Left <= TRY_W'(MAX_TRIES);
      Unlocked <= 1'b0;
      Alarm <= 1'b0;
      Duress <= 1'b0;
    end else begin
      state_q <= state_n;
      code_q <= code_n;
      shadow_q <= shadow_n;
      Digit_Idx <= idx_n;
      mm_q <= mm_n;
      mr_q <= mr_n;
      Tries_Left <= tries_n;
      Unlocked <= state_n inside {S_OPEN, S_CHG_NEW, S_CHG_CONFIRM};
      Alarm <= state_n == S_LOCKOUT;
      Duress <= duress_n;
    end
  assign Selector = state_q;
endmodule

// File: tb/tb_combo_lock_core.sv
// tb_combo_lock_core: scoreboard bench comparing the lock against a sequence-level reference model
module tb_combo_lock_core;
  localparam int L = 4, MT = 3, LC = 16;
  localparam int M_LOCKED = 0, M_ENTRY = 1, M_OPEN = 2, M_CHGN = 3, M_CHGC = 4, M_LOCKOUT = 5;
`ifdef LOCK_DURESS_EN
  localparam bit DUR = 1'b1;
`else
  localparam bit DUR = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b1, oc = 1'b0, va = 1'b0, ch = 1'b0;
  logic [3:0] num = '0;
  logic unl, alm, dur;
  logic [2:0] idx;
  logic [3:0] tries;
  logic [2:0] sel;
  typedef struct packed {
    logic u;
    logic a;
    logic d;
    logic [2:0] i;
    logic [3:0] t;
    logic [2:0] s;
  } obs_t;
  obs_t q[$];
  int n_cmp = 0, n_bad = 0;
  int mode, tries_m, rem;
  bit dur_m;
  int code_m[4], newc[4];
  int ent[$];

  combo_lock_core #(
    .CODE_LEN(4), .DIGIT_W(4), .DEFAULT_CODE(16'h1234), .MAX_TRIES(MT), .LOCKOUT_CYCLES(LC)
  ) dut (
    .Clock(clk), .Reset_n(rst_n), .Open_Close(oc), .Validate(va), .Change(ch), .Number(num),
    .Unlocked(unl), .Alarm(alm), .Duress(dur), .Digit_Idx(idx), .Tries_Left(tries), .Selector(sel)
  );

  always #5 clk = ~clk;

  function automatic bit seq_eq(input int a[4], input bit rev);
    for (int i = 0; i < L; i++) if (ent[i] != a[rev ? L - 1 - i : i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic obs_t expected();
    obs_t e;
    e.u = mode == M_OPEN || mode == M_CHGN || mode == M_CHGC;
    e.a = mode == M_LOCKOUT;
    e.d = dur_m;
    e.i = 3'(ent.size());
    e.t = 4'(tries_m);
    e.s = 3'(mode);
    return e;
  endfunction

  task automatic model_reset();
    mode = M_LOCKED; tries_m = MT; rem = 0; dur_m = 1'b0;
    code_m = '{1, 2, 3, 4}; newc = '{0, 0, 0, 0};
    ent.delete();
  endtask

  task automatic model(input bit o, v_in, c_in, input int n);
    bit c, v;
    c = c_in & ~o;
    v = v_in & ~o & ~c_in;
    if (mode == M_LOCKED || mode == M_ENTRY) begin
      if (o && mode == M_ENTRY) begin
        mode = M_LOCKED; ent.delete();
      end else if (v) begin
        ent.push_back(n); mode = M_ENTRY;
        if (ent.size() == L) begin
          if (seq_eq(code_m, 1'b0)) begin mode = M_OPEN; tries_m = MT; end
          else if (DUR && seq_eq(code_m, 1'b1)) begin mode = M_OPEN; dur_m = 1'b1; end
          else begin
            tries_m--;
            if (tries_m == 0) begin mode = M_LOCKOUT; rem = LC; end
            else mode = M_LOCKED;
          end
          ent.delete();
        end
      end
    end else if (mode == M_OPEN) begin
      if (o) mode = M_LOCKED;
      else if (c) mode = M_CHGN;
    end else if (mode == M_CHGN || mode == M_CHGC) begin
      if (o) begin
        mode = M_OPEN; ent.delete();
      end else if (v) begin
        ent.push_back(n);
        if (ent.size() == L) begin
          if (mode == M_CHGN) begin
            for (int i = 0; i < L; i++) newc[i] = ent[i];
            mode = M_CHGC;
          end else begin
            if (seq_eq(newc, 1'b0)) code_m = newc;
            mode = M_OPEN;
          end
          ent.delete();
        end
      end
    end else begin
      rem--;
      if (rem == 0) begin mode = M_LOCKED; tries_m = MT; end
    end
  endtask

  task automatic check(input string nm, input obs_t g, input obs_t e);
    n_cmp++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL %s t=%0t got u=%0b a=%0b d=%0b idx=%0d tries=%0d sel=%0d expected u=%0b a=%0b d=%0b idx=%0d tries=%0d sel=%0d",
               nm, $time, g.u, g.a, g.d, g.i, g.t, g.s, e.u, e.a, e.d, e.i, e.t, e.s);
    end
  endtask

  task automatic step(input bit o, v, c, input int n);
    @(negedge clk);
    rst_n = 1'b1; oc = o; va = v; ch = c; num = 4'(n);
    model(o, v, c, n);
    q.push_back(expected());
  endtask

  task automatic enter(input int d[4]);
    for (int i = 0; i < L; i++) step(1'b0, 1'b1, 1'b0, d[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; oc = 1'b0; va = 1'b0; ch = 1'b0;
    #1;
    model_reset();
    check("async_reset", {unl, alm, dur, idx, tries, sel}, expected());
    q.push_back(expected());
  endtask

  function automatic int target();
    int p;
    p = ent.size();
    if (mode == M_CHGN) return int'($urandom_range(0, 15));
    if (mode == M_CHGC) return newc[p];
    return code_m[p];
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) check("cycle", {unl, alm, dur, idx, tries, sel}, q.pop_front());
    end
  end

  initial begin
    int r, d;
    model_reset();
    do_reset();
    enter('{1, 2, 3, 4});
    idle(2);
    step(1'b1, 1'b0, 1'b0, 0);
    for (int k = 0; k < 3; k++) begin
      enter('{1, 2, 3, 5});
      idle(1);
    end
    for (int k = 0; k < 20; k++) step(1'b0, 1'b1, k[0], 1);
    enter('{1, 2, 3, 4});
    step(1'b0, 1'b0, 1'b1, 0);
    enter('{9, 8, 7, 6});
    enter('{9, 8, 7, 6});
    step(1'b1, 1'b0, 1'b0, 0);
    enter('{1, 2, 3, 4});
    enter('{9, 8, 7, 6});
    step(1'b0, 1'b0, 1'b1, 0);
    enter('{9, 8, 7, 6});
    step(1'b0, 1'b1, 1'b0, 9);
    step(1'b0, 1'b1, 1'b0, 8);
    do_reset();
    enter('{1, 2, 3, 4});
    step(1'b0, 1'b0, 1'b1, 0);
    enter('{9, 8, 7, 6});
    enter('{9, 8, 7, 0});
    step(1'b1, 1'b0, 1'b0, 0);
    enter('{1, 2, 3, 4});
    step(1'b1, 1'b0, 1'b0, 0);
    step(1'b0, 1'b1, 1'b0, 1);
    step(1'b0, 1'b1, 1'b0, 2);
    step(1'b1, 1'b1, 1'b0, 3);
    idle(1);
    enter('{4, 3, 2, 1});
    idle(1);
    for (int k = 0; k < 3000; k++) begin
      r = int'($urandom_range(0, 99));
      if (r == 0) do_reset();
      else begin
        d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : target();
        step(r < 5, r >= 3 && r < 70, r >= 5 && r < 9, d);
      end
    end
    idle(2);
    @(posedge clk);
    #2;
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain got %0d pending expected 0 pending", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/combo_lock_core.md
# combo_lock_core

Parametrised combination-lock controller: next generation of the board lock with N-digit codes, a retry limit, a timed lockout and verified code change. It sits behind the button debouncers and ahead of the seven-segment driver. It takes single-cycle button pulses plus a digit bus and produces lock status, alarm and display-select outputs.

## Interface
- CODE_LEN, 4: digits per code (2..8)
- DIGIT_W, 4: bits per digit
- DEFAULT_CODE, 16'h1234: code loaded at reset, CODE_LEN*DIGIT_W bits, digit 0 in MSBs
- MAX_TRIES, 3: consecutive failed entries before lockout (1..15)
- LOCKOUT_CYCLES, 1024: lockout duration in clocks (≥2)
- Clock  in  1  system clock, all logic rising-edge
- Reset_n  in  1  asynchronous active-low reset
- Open_Close  in  1  debounced single-cycle pulse
- Validate  in  1  debounced single-cycle pulse; latches Number as next digit
- Change  in  1  debounced single-cycle pulse
- Number  in  DIGIT_W  digit value
- Unlocked  out  1  lock open
- Alarm  out  1  lockout active
- Duress  out  1  silent-alarm flag (macro only; tied 0 otherwise)
- Digit_Idx  out  $clog2(CODE_LEN+1)  digits entered in current sequence
- Tries_Left  out  4  remaining attempts
- Selector  out  3  display mode: 0 LOCKED, 1 ENTRY, 2 OPEN, 3 CHG_NEW, 4 CHG_CONFIRM, 5 LOCKOUT

## Operation
- States: LOCKED, ENTRY, OPEN, CHG_NEW, CHG_CONFIRM, LOCKOUT; Selector encodes state.
- Same-cycle pulse priority: Open_Close > Change > Validate; lower-priority pulses dropped.
- LOCKED: Validate compares Number with code[0], sets mismatch flag, Digit_Idx=1, -> ENTRY. Others ignored.
- ENTRY: each Validate compares against code[Digit_Idx], ORs into mismatch flag, increments Digit_Idx. On CODE_LEN-th digit: match -> OPEN, Tries_Left reloaded to MAX_TRIES; mismatch -> Tries_Left-1, -> LOCKED; if it reaches 0 -> LOCKOUT. Open_Close aborts -> LOCKED, no try consumed. Digit_Idx clears on exit.
- Only the mismatch flag is kept; entered digits are never stored.
- OPEN: Open_Close -> LOCKED. Change -> CHG_NEW. Validate ignored.
- CHG_NEW: CODE_LEN Validates fill shadow register, then -> CHG_CONFIRM.
- CHG_CONFIRM: CODE_LEN Validates compared against shadow; all match -> code register := shadow, -> OPEN; any mismatch -> shadow discarded, code unchanged, -> OPEN. Open_Close in either CHG state aborts -> OPEN, code unchanged.
- LOCKOUT: Alarm=1; all pulses ignored; lockout_timer counts LOCKOUT_CYCLES, then -> LOCKED, Tries_Left=MAX_TRIES, Alarm=0.
- Reset (any time, including mid-entry or mid-change): state LOCKED, code=DEFAULT_CODE, shadow=0, Digit_Idx=0, Tries_Left=MAX_TRIES, Unlocked=0, Alarm=0, Duress=0, Selector=0.

## Timing
- All outputs registered; response visible the cycle after the pulse edge.
- Final Validate at edge N -> Unlocked=1 (or Tries_Left update) at N+1.
- Lockout: Alarm rises at N+1 after failing digit and falls exactly LOCKOUT_CYCLES cycles later.
- Code register commit occurs on the same edge as the CHG_CONFIRM -> OPEN transition.
- Back-to-back Validates on consecutive cycles are all accepted.

## Configuration
- LOCK_DURESS_EN defined: ENTRY additionally tracks a second mismatch flag against the reversed code (code[CODE_LEN-1-i]). Reversed match (and not a forward match) opens the lock like a normal match and also sets Duress=1. Duress stays set until reset and does not affect Tries_Left.
- Undefined: no reversed comparison; Duress tied 0; reversed entry counts as failure.

## Structure
- Package lock_pkg: state enum, Selector encodings, IDX_W/TRY_W width constants.
- Sub-module lockout_timer: load/count-down of $clog2(LOCKOUT_CYCLES) bits, asserts done for one cycle at expiry.
- Code and shadow registers: flat CODE_LEN*DIGIT_W vectors, digit i indexed by part-select.

## Test plan (CODE_LEN=4, DIGIT_W=4, DEFAULT_CODE=16'h1234, MAX_TRIES=3, LOCKOUT_CYCLES=16)
- Reset, Validate 1,2,3,4 -> Unlocked=1 next cycle, Selector=2, Tries_Left=3.
- Enter 1,2,3,5 three times -> Tries_Left 2,1, then Alarm=1 for exactly 16 cycles; Validates during lockout ignored; then LOCKED, Tries_Left=3.
- From OPEN: Change, 9,8,7,6, confirm 9,8,7,6; Open_Close; enter 1,2,3,4 -> fails; enter 9,8,7,6 -> Unlocked=1.
- Change with confirm 9,8,7,0 -> back to OPEN; relock; 1,2,3,4 still unlocks.
- Open_Close and Validate same cycle mid-entry -> abort to LOCKED, Digit_Idx=0, Tries_Left unchanged; Reset_n low mid-CHG_CONFIRM -> all reset values, code=1234.
- LOCK_DURESS_EN: enter 4,3,2,1 -> Unlocked=1, Duress=1; without macro -> Tries_Left=2.
